// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory responder: funct3 encodings,
// responder FSM states and byte-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Lanes touched by an access of the given size at byte offset addr_lo.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr_lo;
      F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Unsupported encodings count as misaligned so they are suppressed too.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word from a memory word and applies
// sign or zero extension according to funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = word_i[{addr_lo_i, 3'b000} +: 8];
    half_s = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'h000000, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'h0000, half_s};
      F3_W:    data_o = word_i;
      default: data_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data memory: word array with byte-lane stores, extended loads,
// programmable wait states that stall the pipeline, and misalignment flagging.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqM,
  input  logic        WeM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0]   mem_q [DEPTH];
  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;

  logic [AW-1:0] word_idx_s;
  logic [1:0]    addr_lo_s;
  logic          misalign_s;
  logic          go_s;
  logic          complete_s;
  logic          wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   load_s;
  logic          unused_addr_s;

  assign word_idx_s    = ALUResultM[AW+1:2];
  assign addr_lo_s     = ALUResultM[1:0];
  assign unused_addr_s = ^ALUResultM[31:AW+2];
  assign misalign_s    = misaligned(Funct3M, addr_lo_s);
  assign go_s          = ReqM & ~misalign_s & ~reset;

  // Completion: first cycle when there are no wait states, else when the countdown expires.
  always_comb begin
    complete_s = 1'b0;
    if (go_s) begin
      if (state_q == WAIT) begin
        complete_s = (count_q == 4'd0);
      end else begin
        complete_s = (WAIT_CYCLES == 0);
      end
    end else begin
      complete_s = 1'b0;
    end
  end

  // Next-state logic; a dropped request aborts an access in progress.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (go_s && (WAIT_CYCLES != 0)) begin
          state_d = WAIT;
          count_d = CNT_INIT;
        end else begin
          state_d = IDLE;
          count_d = 4'd0;
        end
      end
      WAIT: begin
        if (!ReqM || (count_q == 4'd0)) begin
          state_d = IDLE;
          count_d = 4'd0;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Replicate store data across lanes so byte_enable alone picks the target bytes.
  always_comb begin
    case (Funct3M)
      F3_B:    wdata_s = {4{WriteDataM[7:0]}};
      F3_H:    wdata_s = {2{WriteDataM[15:0]}};
      default: wdata_s = WriteDataM;
    endcase
  end

  assign be_s    = byte_enable(Funct3M, addr_lo_s);
  assign wr_en_s = complete_s & WeM;

  // Memory array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  load_extend u_load_extend (
    .word_i    (mem_q[word_idx_s]),
    .addr_lo_i (addr_lo_s),
    .funct3_i  (Funct3M),
    .data_o    (load_s)
  );

  assign StallM    = go_s & ~complete_s;
  assign MisalignM = ReqM & misalign_s & ~reset;
  assign ReadDataM = (complete_s & ~WeM) ? load_s : 32'h00000000;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 2 wait states) driven by
// directed and random accesses, checked against a byte-addressed memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [2:0]  f3 [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic [1:0]  stall;
  logic [1:0]  mis;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] mb [2][1024];
  int waits [2];
  logic [31:0] got;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .ReqM(req[0]), .WeM(we[0]), .Funct3M(f3[0]),
    .ALUResultM(addr[0]), .WriteDataM(wd[0]), .ReadDataM(rd[0]),
    .StallM(stall[0]), .MisalignM(mis[0]));

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .ReqM(req[1]), .WeM(we[1]), .Funct3M(f3[1]),
    .ALUResultM(addr[1]), .WriteDataM(wd[1]), .ReadDataM(rd[1]),
    .StallM(stall[1]), .MisalignM(mis[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int acc_size(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic logic model_mis(input logic [2:0] f, input logic [31:0] a);
    if (f == 3'd3 || f > 3'd5) return 1'b1;
    return (a % acc_size(f)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    int sz = acc_size(f);
    for (int k = 0; k < sz; k++) v = v | (32'(mb[d][(a + k) % 1024]) << (8 * k));
    if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  // One access on instance d; leaves the request asserted so a following call is back-to-back.
  task automatic access(input int d, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] data,
                        input string tag, output logic [31:0] rd_o);
    logic e_mis = model_mis(f, a);
    logic [31:0] e_rd = (w || e_mis) ? 32'd0 : model_load(d, f, a);
    int n = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; wd[d] = data;
    #1;
    while (stall[d] && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, ".stall"}, 32'(n), e_mis ? 32'd0 : 32'(waits[d]));
    chk({tag, ".mis"}, 32'(mis[d]), 32'(e_mis));
    if (!w) chk({tag, ".rd"}, rd[d], e_rd);
    rd_o = rd[d];
    if (w && !e_mis)
      for (int k = 0; k < acc_size(f); k++) mb[d][(a + k) % 1024] = data[8*k +: 8];
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  initial begin
    logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0] st_f3 [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    waits[0] = 0;
    waits[1] = 2;
    for (int d = 0; d < 2; d++) begin
      f3[d] = 3'd0; addr[d] = 32'd0; wd[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset.stall", 32'(stall[d]), 32'd0);
      chk("reset.mis", 32'(mis[d]), 32'd0);
      chk("reset.rd", rd[d], 32'd0);
    end

    // Known contents for the region used below.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) access(d, 1'b1, 3'd2, 32'(4 * i), 32'd0, "init", got);
      idle(d);
    end

    // Single-cycle instance.
    access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "w0.sw", got);
    access(0, 1'b0, 3'd2, 32'h10, 32'd0, "w0.lw", got);
    chk("w0.lw.const", got, 32'hDEADBEEF);
    access(0, 1'b1, 3'd2, 32'h20, 32'h11223344, "w0.sw20", got);
    access(0, 1'b0, 3'd2, 32'h22, 32'd0, "w0.lw_mis", got);
    access(0, 1'b1, 3'd1, 32'h23, 32'hBEEF, "w0.sh_mis", got);
    access(0, 1'b0, 3'd2, 32'h20, 32'd0, "w0.after_mis", got);
    chk("w0.after_mis.const", got, 32'h11223344);
    idle(0);

    // Two-wait-state instance, back-to-back and lanes.
    access(1, 1'b0, 3'd2, 32'h10, 32'd0, "w2.lw", got);
    access(1, 1'b1, 3'd2, 32'h20, 32'h11223344, "w2.sw", got);
    access(1, 1'b0, 3'd2, 32'h20, 32'd0, "w2.lw_b2b", got);
    chk("w2.lw_b2b.const", got, 32'h11223344);
    access(1, 1'b1, 3'd0, 32'h21, 32'h000000AA, "w2.sb", got);
    access(1, 1'b0, 3'd2, 32'h20, 32'd0, "w2.lw_lane", got);
    chk("w2.lane.const", got, 32'h1122AA44);
    access(1, 1'b0, 3'd0, 32'h21, 32'd0, "w2.lb", got);
    chk("w2.lb.const", got, 32'hFFFFFFAA);
    access(1, 1'b0, 3'd4, 32'h21, 32'd0, "w2.lbu", got);
    chk("w2.lbu.const", got, 32'h000000AA);
    access(1, 1'b0, 3'd1, 32'h22, 32'd0, "w2.lh", got);
    chk("w2.lh.const", got, 32'h00001122);
    access(1, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, "w2.sw_wrap", got);
    access(1, 1'b0, 3'd2, 32'h0, 32'd0, "w2.lw_wrap", got);
    chk("w2.wrap.const", got, 32'hCAFEF00D);
    idle(1);

    // Reset during the wait of a store: nothing is written.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'd2; addr[1] = 32'h30; wd[1] = 32'h12345678;
    #1;
    chk("rst_wait.stall_on", 32'(stall[1]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req[1] = 1'b0;
    #1;
    chk("rst_wait.stall_off", 32'(stall[1]), 32'd0);
    access(1, 1'b0, 3'd2, 32'h30, 32'd0, "rst_wait.lw", got);
    chk("rst_wait.const", got, 32'd0);
    idle(1);

    // Request withdrawn mid-wait: nothing is written.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; f3[1] = 3'd2; addr[1] = 32'h34; wd[1] = 32'h55AA55AA;
    @(negedge clk);
    req[1] = 1'b0;
    access(1, 1'b0, 3'd2, 32'h34, 32'd0, "abort.lw", got);
    chk("abort.const", got, 32'd0);
    idle(1);

    // Random traffic against the model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        logic w = 1'($urandom_range(1, 0));
        logic [2:0] f = w ? st_f3[$urandom_range(3, 0)] : ld_f3[$urandom_range(7, 0)];
        logic [31:0] a = 32'($urandom_range(127, 0)) | (32'($urandom_range(3, 0)) << 10);
        access(d, w, f, a, $urandom, "rand", got);
      end
      idle(d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
